fnd_controller: RTL and testbench
=================================

# fnd_controller

- Display-side consumer for the 8-bit value produced by the processor/counter datapath.
- Accepts a value over a valid/ready handshake and converts it to three BCD digits with a sequential double-dabble.
- Drives a 4-digit, common-anode seven-segment display (FND) by time-multiplexed scanning with leading-zero blanking.
- Sits between the processor's `out` bus and the board FND pins.

## Interface

Parameters:
- `REFRESH_DIV`, default 100_000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset. Sampled only on the rising edge of `clk`.
- `in_data`  in  8  unsigned value to display, 0..255.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a new value.
- `fnd_com`  out  4  digit enables, active-low; bit0 is the rightmost (ones) digit.
- `fnd_font`  out  8  segments `{dp,g,f,e,d,c,b,a}`, active-low; `dp` is always 1.

## Operation

- Control FSM states and transitions:
  - IDLE → CONVERT on `in_valid && in_ready`; `in_data` is captured into the shift register.
  - CONVERT runs 8 iterations. Each iteration: every BCD nibble ≥ 5 gets +3, then `{bcd[11:0], bin[7:0]}` shifts left by 1. A 3-bit iteration counter controls it; at count 7 → LOAD.
  - LOAD copies the 12-bit BCD into the display registers `d2,d1,d0`, then → IDLE.
- `in_ready` = 1 only in IDLE. `in_valid` is ignored outside IDLE. No queuing: values presented while busy are lost unless the producer holds them.
- Display registers hold their value until the next LOAD.
- Leading-zero blanking:
  - digit3 is always blank.
  - digit2 is blank if `d2 == 0`.
  - digit1 is blank if `d2 == 0 && d1 == 0`.
  - digit0 is never blank.
- Font encoding (hex): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF. Nibble values above 9 are unreachable; map them to blank.
- Scan:
  - A divider counts 0..REFRESH_DIV-1 and wraps; `tick` is asserted on the terminal count.
  - A 2-bit digit index increments on `tick` and wraps 3→0.
  - `fnd_com` has exactly one bit low, the bit for the current index.
- Reset (active `reset == 0`), including mid-conversion:
  - FSM to IDLE; iteration counter, divider, digit index, shift and display registers to 0.
  - Any conversion in progress is discarded.
  - Registered outputs after reset: `in_ready` = 1, `fnd_com` = 4'b1110, `fnd_font` = 8'hC0 (shows "0").

## Timing

- Handshake accepted at edge T (IDLE, `in_valid` = 1): state is CONVERT for cycles T+1..T+8, LOAD in T+9, IDLE again in T+10.
- `in_ready` is low for cycles T+1..T+9 and high from T+10. Accept-to-accept throughput is 10 cycles.
- Display registers update at the edge ending LOAD. `fnd_font` reflects the new value one cycle later (registered output), i.e. visible from cycle T+11 while the matching digit is selected.
- Digit index changes on the edge where `tick` = 1. `fnd_com`/`fnd_font` are registered and change on the following edge. Each digit is enabled for exactly REFRESH_DIV cycles.
- A LOAD that coincides with a scan tick: the new digit index and the new display data both take effect together; no glitch pattern is emitted.
- The scan runs independently of the FSM and never stalls.

## Structure

- Package `fnd_pkg`:
  - FSM state enum (IDLE, CONVERT, LOAD);
  - the ten segment constants plus `SEG_BLANK`;
  - `NUM_DIGITS = 4`.
- Sub-module `bin2bcd_seq`: 8-bit sequential double-dabble with a start/done interface, holding the shift register and iteration counter.
- Top level `fnd_controller`:
  - handshake FSM;
  - display registers;
  - scan divider and digit index;
  - blanking, font lookup and output registers.

## Test plan

- Reset: hold `reset` = 0 for 3 cycles, then release → `in_ready` = 1, `fnd_com` = 1110, `fnd_font` = C0; with `REFRESH_DIV` = 4, `fnd_com` steps 1101, 1011, 0111, 1110 every 4 cycles.
- Convert 255: one-cycle `in_valid` with `in_data` = 8'hFF → `in_ready` low for exactly 9 cycles; the scan then shows digit0=92, digit1=92, digit2=A4, digit3=FF.
- Blanking: `in_data` = 7 → digit0=F8, digits 1–3=FF. Then `in_data` = 40 → digit0=C0, digit1=99, digits 2–3=FF.
- Busy drop: hold `in_valid` = 1 with `in_data` = 9, and 3 cycles after acceptance change `in_data` to 5 → the display shows 9. The 5 is accepted only once `in_ready` returns high, then shows 5.
- Reset mid-conversion: accept 200, assert `reset` at cycle T+4 → IDLE next cycle, display reads "0", no LOAD of 200 ever occurs.
- Sweep 0..255 through the handshake → every displayed digit triple equals the decimal value, with correct blanking.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND display controller.
package fnd_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BCD_W      = 12;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned ITER_W     = 3;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned SEG_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_e;

    // Three BCD digits, hundreds in the top nibble.
    typedef struct packed {
        logic [NIB_W-1:0] d2;
        logic [NIB_W-1:0] d1;
        logic [NIB_W-1:0] d0;
    } bcd_t;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp kept off.
    localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
    localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
    localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
    localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
    localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    // BCD nibble to segment pattern; non-decimal codes are shown blank.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_controller_bin2bcd.sv
// Sequential 8-bit double-dabble: one add-3/shift iteration per step cycle.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              step,
    output logic              done_c,
    output bcd_t              bcd
);

    localparam int unsigned SR_W = BCD_W + DATA_W;

    logic [SR_W-1:0]   sr_q,  sr_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0]  adj_c;

    // Add-3 correction on every BCD nibble, then shift the whole register left.
    always_comb begin
        adj_c = sr_q[SR_W-1:DATA_W];
        sr_d  = sr_q;
        cnt_d = cnt_q;
        for (int i = 0; i < int'(BCD_W / NIB_W); i++) begin
            if (adj_c[i*NIB_W +: NIB_W] >= 4'd5) begin
                adj_c[i*NIB_W +: NIB_W] = adj_c[i*NIB_W +: NIB_W] + 4'd3;
            end
        end
        if (start) begin
            sr_d  = {BCD_W'(0), din};
            cnt_d = '0;
        end else if (step) begin
            sr_d  = {adj_c[BCD_W-2:0], sr_q[DATA_W-1:0], 1'b0};
            cnt_d = cnt_q + ITER_W'(1);
        end
    end

    // Shift register and iteration counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_c = step && (cnt_q == ITER_W'(DATA_W - 1));
    assign bcd    = bcd_t'(sr_q[SR_W-1:DATA_W]);

endmodule

// File: rtl/fnd_controller.sv
// Handshaked 8-bit value to 4-digit multiplexed common-anode FND driver.
module fnd_controller
    import fnd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic [SEG_W-1:0]      fnd_font
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_e                state_q, state_d;
    logic                  start_c, step_c, load_c, done_c;
    bcd_t                  bcd;
    bcd_t                  disp_q, disp_d;
    logic                  in_ready_q, in_ready_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  tick_c;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] com_q, com_d;
    logic [SEG_W-1:0]      font_q, font_d;
    logic [NIB_W-1:0]      nib_c;
    logic                  blank_c;

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (start_c),
        .din    (in_data),
        .step   (step_c),
        .done_c (done_c),
        .bcd    (bcd)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: accept, eight conversion steps, load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CONVERT;
            CONVERT: if (done_c)   state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; ready is registered from the next state so it tracks IDLE exactly.
    always_comb begin
        start_c    = (state_q == IDLE) && in_valid;
        step_c     = (state_q == CONVERT);
        load_c     = (state_q == LOAD);
        in_ready_d = (state_d == IDLE);
    end

    // Display registers, scan divider and digit index.
    always_comb begin
        disp_d = load_c ? bcd : disp_q;
        tick_c = (div_q == DIV_W'(REFRESH_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
        idx_d  = tick_c ? idx_q + IDX_W'(1) : idx_q;
    end

    // Digit select, leading-zero blanking and font lookup for the current index.
    always_comb begin
        nib_c   = disp_q.d0;
        blank_c = 1'b0;
        case (idx_q)
            2'd0: begin
                nib_c   = disp_q.d0;
                blank_c = 1'b0;
            end
            2'd1: begin
                nib_c   = disp_q.d1;
                blank_c = (disp_q.d2 == '0) && (disp_q.d1 == '0);
            end
            2'd2: begin
                nib_c   = disp_q.d2;
                blank_c = (disp_q.d2 == '0);
            end
            default: begin
                nib_c   = '0;
                blank_c = 1'b1;
            end
        endcase
        font_d = blank_c ? SEG_BLANK : seg_encode(nib_c);
        com_d  = ~(NUM_DIGITS'(1) << idx_q);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_ready_q <= 1'b1;
            disp_q     <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            com_q      <= 4'b1110;
            font_q     <= SEG_0;
        end else begin
            in_ready_q <= in_ready_d;
            disp_q     <= disp_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            com_q      <= com_d;
            font_q     <= font_d;
        end
    end

    assign in_ready = in_ready_q;
    assign fnd_com  = com_q;
    assign fnd_font = font_q;

endmodule

// File: tb/tb_fnd_controller.sv
// Self-checking bench for fnd_controller with a short scan period.
module tb_fnd_controller;

    localparam int unsigned RDIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] fnd_com;
    logic [7:0] fnd_font;

    int checks   = 0;
    int failures = 0;

    logic [7:0] seg_tab [10];

    typedef struct {
        logic [7:0]  data;
        logic [31:0] fonts;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    fnd_controller #(.REFRESH_DIV(RDIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fnd_com  (fnd_com),
        .fnd_font (fnd_font)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input int v);
        int d0, d1, d2;
        logic [7:0] f1, f2;
        d0 = v % 10;
        d1 = (v / 10) % 10;
        d2 = v / 100;
        f2 = (d2 == 0) ? 8'hFF : seg_tab[d2];
        f1 = (d2 == 0 && d1 == 0) ? 8'hFF : seg_tab[d1];
        return {8'hFF, f2, f1, seg_tab[d0]};
    endfunction

    function automatic int com_to_idx(input logic [3:0] c);
        case (c)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Collect one font per digit over more than a full scan round.
    task automatic read_display(output logic [31:0] fonts);
        logic [3:0] seen;
        int idx;
        seen  = '0;
        fonts = '1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idx = com_to_idx(fnd_com);
            checks++;
            if (idx < 0) begin
                failures++;
                $display("FAIL com_onehot: got %b expected one low bit", fnd_com);
            end else begin
                fonts[idx*8 +: 8] = fnd_font;
                seen[idx] = 1'b1;
            end
        end
        check("scan_all_digits", 32'(seen), 32'hF);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
    endtask

    // One-cycle valid pulse; returns how many cycles ready stayed low afterwards.
    task automatic send(input logic [7:0] v, output int low_cycles);
        bit ok;
        wait_ready(ok);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        low_cycles = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                low_cycles = i;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] f;
        logic [31:0] e;
        logic [3:0]  seq [4];
        int low, idx, busy;
        bit ok;

        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        vecs[0]  = '{8'd255, 32'hFF_A4_92_92};
        vecs[1]  = '{8'd7,   32'hFF_FF_FF_F8};
        vecs[2]  = '{8'd40,  32'hFF_FF_99_C0};
        vecs[3]  = '{8'd0,   32'hFF_FF_FF_C0};
        vecs[4]  = '{8'd100, 32'hFF_F9_C0_C0};
        vecs[5]  = '{8'd9,   32'hFF_FF_FF_90};
        vecs[6]  = '{8'd128, 32'hFF_F9_A4_80};
        vecs[7]  = '{8'd99,  32'hFF_FF_90_90};
        vecs[8]  = '{8'd200, 32'hFF_A4_C0_C0};
        vecs[9]  = '{8'd10,  32'hFF_FF_F9_C0};
        vecs[10] = '{8'd5,   32'hFF_FF_FF_92};

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        check("reset_fnd_com",  32'(fnd_com),  32'hE);
        check("reset_fnd_font", 32'(fnd_font), 32'hC0);

        // Scan stepping: each later digit held exactly RDIV cycles.
        seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fnd_com != 4'b1110) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL scan_start: got fnd_com=%b expected a change within 20 cycles", fnd_com);
        end
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < int'(RDIV); k++) begin
                if (p != 0 || k != 0) @(negedge clk);
                check("scan_step_com", 32'(fnd_com), 32'(seq[p]));
            end
        end

        // Directed vector table.
        foreach (vecs[i]) begin
            send(vecs[i].data, low);
            check("busy_cycles", 32'(low), 32'd9);
            read_display(f);
            check("table_display", f, vecs[i].fonts);
        end

        // Busy drop: data changes while converting are ignored until ready returns.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'd9;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 in_data = 8'd5;
        wait_ready(ok);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = model(9);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_second_accept", 32'(in_ready), 32'h0);
            idx = com_to_idx(fnd_com);
            if (idx < 0) idx = 0;
            check("busy_holds_9", 32'(fnd_font), 32'(e[idx*8 +: 8]));
        end
        wait_ready(ok);
        read_display(f);
        check("busy_then_5", f, model(5));

        // Reset in the middle of converting 200.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midreset_in_ready", 32'(in_ready), 32'h1);
        check("midreset_com",      32'(fnd_com),  32'hE);
        check("midreset_font",     32'(fnd_font), 32'hC0);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!in_ready) busy++;
        end
        check("midreset_no_busy", 32'(busy), 32'd0);
        read_display(f);
        check("midreset_display", f, model(0));

        // Full sweep through the handshake.
        for (int v = 0; v < 256; v++) begin
            send(8'(v), low);
            check("sweep_busy", 32'(low), 32'd9);
            read_display(f);
            check("sweep_display", f, model(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
